// File: rtl/ppc60x_master.sv
// ppc60x_master: PowerPC 60x bus master. It turns one local request into a
// bus-request / address-tenure / data-tenure sequence. The sequence supports
// ARTRY retries, TEA aborts and a TA/TEA timeout.
// Optional feature: define PPC60X_BURST_EN to issue 4-beat bursts when
// req_size == 000. The burst read data is then exposed on rsp_burst.
module ppc60x_master #(
    parameter int RETRY_MAX  = 8,
    parameter int TA_TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [0:31]  req_addr,
    input  logic [0:2]   req_size,
    input  logic [0:31]  req_wdata,
    output logic         rsp_valid,
    output logic [0:31]  rsp_rdata,
    output logic         rsp_err,
`ifdef PPC60X_BURST_EN
    output logic [0:127] rsp_burst,
`endif
    output logic         BR0,
    input  logic         BG0,
    input  logic         DBG0,
    output logic         TS,
    output logic [0:31]  A,
    output logic [0:4]   TT,
    output logic [0:2]   TSIZ,
    output logic         TBST,
    input  logic         AACK,
    input  logic         ARTRY,
    input  logic         TA,
    input  logic         TEA,
    output logic [0:31]  DL_O,
    input  logic [0:31]  DL_I,
    output logic         DL_OE
);

    localparam int RTY_W = (RETRY_MAX  < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam int TMO_W = (TA_TIMEOUT < 2) ? 1 : $clog2(TA_TIMEOUT + 1);

    localparam logic [0:4] TT_WRITE = 5'b00010;
    localparam logic [0:4] TT_READ  = 5'b01010;
`ifdef PPC60X_BURST_EN
    localparam logic [0:4] TT_WBURST = 5'b00110;
    localparam logic [0:4] TT_RBURST = 5'b01110;
`endif

    typedef enum logic [2:0] {
        IDLE, BREQ, ADDR, AWAIT, DREQ, DATA, RESP
    } state_t;

    state_t             state_q, state_d;
    logic               req_write_q, req_write_d;
    logic [0:31]        req_addr_q, req_addr_d;
    logic [0:2]         req_size_q, req_size_d;
    logic [0:31]        req_wdata_q, req_wdata_d;
    logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               br0_q, br0_d;
    logic               ts_q, ts_d;
    logic [0:31]        a_q, a_d;
    logic [0:4]         tt_q, tt_d;
    logic [0:2]         tsiz_q, tsiz_d;
    logic               tbst_q, tbst_d;
    logic [0:31]        dl_o_q, dl_o_d;
    logic               dl_oe_q, dl_oe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [0:31]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               req_ready_q, req_ready_d;
`ifdef PPC60X_BURST_EN
    logic               burst_q, burst_d;
    logic [1:0]         beat_cnt_q, beat_cnt_d;
    logic [0:127]       rsp_burst_q, rsp_burst_d;
`endif

    logic artry_hit;   // ARTRY seen in its window: retry or give up
    logic abort;       // transaction ends in RESP with rsp_err = 1
    logic capture;     // TA sampled on a data beat
    logic tmo_last;    // this is the final cycle the data tenure may wait

    assign tmo_last = (tmo_cnt_q == TMO_W'(TA_TIMEOUT - 1));

    // Next-state and next-output computation for the whole transaction flow.
    always_comb begin
        // NOTE: every _d defaults to its _q (or a fixed value) first, so no path through this block can infer a latch.
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_size_d  = req_size_q;
        req_wdata_d = req_wdata_q;
        retry_cnt_d = retry_cnt_q;
        a_d         = a_q;
        tt_d        = tt_q;
        tsiz_d      = tsiz_q;
        tbst_d      = tbst_q;
        rsp_rdata_d = rsp_rdata_q;
        artry_hit   = 1'b0;
        abort       = 1'b0;
        capture     = 1'b0;
`ifdef PPC60X_BURST_EN
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        rsp_burst_d = rsp_burst_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_write_d = req_write;
                    req_addr_d  = req_addr;
                    req_size_d  = req_size;
                    req_wdata_d = req_wdata;
                    retry_cnt_d = '0;
`ifdef PPC60X_BURST_EN
                    burst_d     = (req_size == 3'b000);
`endif
                    state_d     = BREQ;
                end
            end
            BREQ: begin
                if (!BG0) state_d = ADDR;
            end
            ADDR: begin
                state_d = AWAIT;
            end
            AWAIT: begin
                if (!ARTRY)     artry_hit = 1'b1;
                else if (!AACK) state_d   = DREQ;
            end
            DREQ: begin
                // The ARTRY window still covers the first cycle after AACK.
                if (!ARTRY && tmo_cnt_q == '0) artry_hit = 1'b1;
                else if (!DBG0)                state_d   = DATA;
                else if (tmo_last) begin
                    state_d = RESP;
                    abort   = 1'b1;
                end
            end
            DATA: begin
                if (!TEA) begin
                    state_d = RESP;
                    abort   = 1'b1;
                end else if (!TA) begin
                    capture = 1'b1;
`ifdef PPC60X_BURST_EN
                    if (burst_q && beat_cnt_q != 2'd3) beat_cnt_d = beat_cnt_q + 2'd1;
                    else                               state_d    = RESP;
`else
                    state_d = RESP;
`endif
                end else if (tmo_last) begin
                    state_d = RESP;
                    abort   = 1'b1;
                end
            end
            RESP: begin
                retry_cnt_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (artry_hit) begin
            if (retry_cnt_q == RTY_W'(RETRY_MAX)) begin
                state_d = RESP;
                abort   = 1'b1;
            end else begin
                retry_cnt_d = retry_cnt_q + RTY_W'(1);
                state_d     = BREQ;
            end
        end

        // Timeout counter only runs while the data tenure is outstanding.
        if ((state_q == DREQ || state_q == DATA) && (state_d == DREQ || state_d == DATA))
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        else
            tmo_cnt_d = '0;

        if (capture && !req_write_q) begin
            rsp_rdata_d = DL_I;
`ifdef PPC60X_BURST_EN
            rsp_burst_d[{beat_cnt_q, 5'd0} +: 32] = DL_I;
`endif
        end
`ifdef PPC60X_BURST_EN
        if (state_d != DATA) beat_cnt_d = '0;
`endif

        // Address-tenure pins: driven in ADDR, held through AWAIT, idle otherwise.
        if (state_d == ADDR) begin
            a_d    = req_addr_q;
            tsiz_d = req_size_q;
`ifdef PPC60X_BURST_EN
            tbst_d = !burst_q;
            if (burst_q) tt_d = req_write_q ? TT_WBURST : TT_RBURST;
            else         tt_d = req_write_q ? TT_WRITE  : TT_READ;
`else
            tbst_d = 1'b1;
            tt_d   = req_write_q ? TT_WRITE : TT_READ;
`endif
        end else if (state_d != AWAIT) begin
            a_d    = '0;
            tt_d   = '0;
            tsiz_d = '0;
            tbst_d = 1'b1;
        end

        br0_d       = (state_d != BREQ);
        ts_d        = (state_d != ADDR);
        dl_oe_d     = (state_d == DATA) && req_write_q;
        dl_o_d      = dl_oe_d ? req_wdata_q : '0;
        rsp_valid_d = (state_d == RESP);
        rsp_err_d   = (state_d == RESP) && abort;
        req_ready_d = (state_d == IDLE);
    end

    // State, latched request, counters and every bus/response output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_size_q  <= '0;
            req_wdata_q <= '0;
            retry_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            br0_q       <= 1'b1;
            ts_q        <= 1'b1;
            a_q         <= '0;
            tt_q        <= '0;
            tsiz_q      <= '0;
            tbst_q      <= 1'b1;
            dl_o_q      <= '0;
            dl_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
`ifdef PPC60X_BURST_EN
            burst_q     <= 1'b0;
            beat_cnt_q  <= '0;
            rsp_burst_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge value of every other.
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_size_q  <= req_size_d;
            req_wdata_q <= req_wdata_d;
            retry_cnt_q <= retry_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            br0_q       <= br0_d;
            ts_q        <= ts_d;
            a_q         <= a_d;
            tt_q        <= tt_d;
            tsiz_q      <= tsiz_d;
            tbst_q      <= tbst_d;
            dl_o_q      <= dl_o_d;
            dl_oe_q     <= dl_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
`ifdef PPC60X_BURST_EN
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_burst_q <= rsp_burst_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign BR0       = br0_q;
    assign TS        = ts_q;
    assign A         = a_q;
    assign TT        = tt_q;
    assign TSIZ      = tsiz_q;
    assign TBST      = tbst_q;
    assign DL_O      = dl_o_q;
    assign DL_OE     = dl_oe_q;
`ifdef PPC60X_BURST_EN
    assign rsp_burst = rsp_burst_q;
`endif

endmodule

// File: tb/tb_ppc60x_master.sv
// tb_ppc60x_master: directed and randomized transactions against ppc60x_master
// (default single-beat build), with a cycle-level bus responder and a
// transaction-level expectation model.
module tb_ppc60x_master;

    localparam int RETRY_MAX  = 8;
    localparam int TA_TIMEOUT = 255;
    localparam int CYC_LIMIT  = 600;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, req_write;
    logic [0:31] req_addr, req_wdata;
    logic [0:2]  req_size;
    logic        rsp_valid, rsp_err;
    logic [0:31] rsp_rdata;
    logic        BR0, BG0, DBG0, TS, TBST, AACK, ARTRY, TA, TEA, DL_OE;
    logic [0:31] A, DL_O, DL_I;
    logic [0:4]  TT;
    logic [0:2]  TSIZ;

    always #5 CLK = ~CLK;

    ppc60x_master #(.RETRY_MAX(RETRY_MAX), .TA_TIMEOUT(TA_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .BR0(BR0), .BG0(BG0), .DBG0(DBG0), .TS(TS), .A(A), .TT(TT), .TSIZ(TSIZ),
        .TBST(TBST), .AACK(AACK), .ARTRY(ARTRY), .TA(TA), .TEA(TEA),
        .DL_O(DL_O), .DL_I(DL_I), .DL_OE(DL_OE)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          bg_w;
        int          aack_w;
        int          dbg_w;
        int          ta_w;
        int          n_artry;   // attempts answered with ARTRY (> RETRY_MAX: every attempt)
        bit          tea;       // TEA asserted together with TA
        bit          never;     // TA never asserted
        bit          junk;      // toggle req_valid/req fields during the transaction
    } stim_t;

    typedef struct {
        int          rsp_cycle;
        int          rsp_count;
        logic [31:0] rdata;
        logic        err;
        int          ts_count;
        int          br_low;
        logic [31:0] a_ts;
        logic [4:0]  tt_ts;
        logic [2:0]  tsiz_ts;
        logic        tbst_ts;
        int          hold_bad;
        int          oe_cycles;
        int          oe_bad;
        int          ready_bad;
        bit          timed_out;
    } obs_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        BG0 = 1'b1; DBG0 = 1'b1; AACK = 1'b1; ARTRY = 1'b1; TA = 1'b1; TEA = 1'b1;
        DL_I = $urandom;
    endtask

    function automatic stim_t base_stim();
        stim_t s;
        s.wr = 1'b0; s.addr = '0; s.size = 3'b100; s.wdata = '0; s.rdata = '0;
        s.bg_w = 0; s.aack_w = 0; s.dbg_w = 0; s.ta_w = 0; s.n_artry = 0;
        s.tea = 1'b0; s.never = 1'b0; s.junk = 1'b0;
        return s;
    endfunction

    task automatic check_reset_vals(input string p);
        check({p, ".BR0"},       32'(BR0),       32'd1);
        check({p, ".TS"},        32'(TS),        32'd1);
        check({p, ".TBST"},      32'(TBST),      32'd1);
        check({p, ".A"},         A,              32'd0);
        check({p, ".DL_O"},      DL_O,           32'd0);
        check({p, ".TSIZ"},      32'(TSIZ),      32'd0);
        check({p, ".TT"},        32'(TT),        32'd0);
        check({p, ".DL_OE"},     32'(DL_OE),     32'd0);
        check({p, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({p, ".rsp_err"},   32'(rsp_err),   32'd0);
        check({p, ".rsp_rdata"}, rsp_rdata,      32'd0);
        check({p, ".req_ready"}, 32'(req_ready), 32'd0);
    endtask

    // Issues one request and plays the bus slave cycle by cycle. Inputs are driven
    // and outputs observed at the falling edge; cycle 0 is the acceptance cycle.
    task automatic run_txn(input stim_t s, output obs_t o);
        int  n, br_run, since_ts, attempt, dcnt, wait_n;
        bit  pend_aack, data_ph, seen_rsp;
        o.rsp_cycle = -1; o.rsp_count = 0; o.rdata = '0; o.err = 1'b0;
        o.ts_count = 0; o.br_low = 0; o.a_ts = '0; o.tt_ts = '0; o.tsiz_ts = '0;
        o.tbst_ts = 1'b0; o.hold_bad = 0; o.oe_cycles = 0; o.oe_bad = 0;
        o.ready_bad = 0; o.timed_out = 1'b0;
        br_run = 0; since_ts = 0; attempt = 0; dcnt = 0;
        pend_aack = 1'b0; data_ph = 1'b0; seen_rsp = 1'b0;

        idle_bus();
        wait_n = 0;
        @(negedge CLK);
        while (req_ready !== 1'b1 && wait_n < 20) begin
            @(negedge CLK);
            wait_n++;
        end
        if (req_ready !== 1'b1) begin
            o.timed_out = 1'b1;
            return;
        end
        req_valid = 1'b1; req_write = s.wr; req_addr = s.addr;
        req_size = s.size; req_wdata = s.wdata;

        n = 0;
        while (1) begin
            @(negedge CLK);
            n++;
            // ---- observe this cycle's outputs ----
            if (!seen_rsp && req_ready !== 1'b0) o.ready_bad++;
            if (BR0 === 1'b0) begin
                o.br_low++;
                br_run++;
            end else br_run = 0;
            if (TS === 1'b0) begin
                o.ts_count++;
                attempt++;
                o.a_ts = A; o.tt_ts = TT; o.tsiz_ts = TSIZ; o.tbst_ts = TBST;
                pend_aack = 1'b1;
                since_ts  = 0;
            end else if (pend_aack) begin
                since_ts++;
                if (A !== s.addr || TT !== o.tt_ts || TSIZ !== s.size) o.hold_bad++;
            end
            if (DL_OE === 1'b1) begin
                o.oe_cycles++;
                if (DL_O !== s.wdata) o.oe_bad++;
            end
            if (rsp_valid === 1'b1) begin
                o.rsp_count++;
                if (!seen_rsp) begin
                    o.rsp_cycle = n; o.rdata = rsp_rdata; o.err = rsp_err;
                end
                seen_rsp = 1'b1;
            end

            // ---- drive this cycle's inputs ----
            BG0 = 1'b1; DBG0 = 1'b1; AACK = 1'b1; ARTRY = 1'b1; TA = 1'b1; TEA = 1'b1;
            DL_I = $urandom;
            req_valid = s.junk && !seen_rsp && ($urandom_range(0, 1) == 1);
            if (s.junk) begin
                req_addr = $urandom; req_wdata = $urandom; req_write = $urandom_range(0, 1) == 1;
            end
            if (BR0 === 1'b0 && br_run > s.bg_w) BG0 = 1'b0;
            if (data_ph) begin
                dcnt++;
                if (dcnt == s.dbg_w + 1) DBG0 = 1'b0;
                if (!s.never && dcnt == s.dbg_w + 2 + s.ta_w) begin
                    TA = 1'b0;
                    DL_I = s.rdata;
                    if (s.tea) TEA = 1'b0;
                    data_ph = 1'b0;
                end
            end
            if (pend_aack && TS === 1'b1 && since_ts == s.aack_w + 1) begin
                AACK = 1'b0;
                pend_aack = 1'b0;
                if (attempt <= s.n_artry) ARTRY = 1'b0;
                else begin
                    data_ph = 1'b1;
                    dcnt    = 0;
                end
            end

            if (seen_rsp && n >= o.rsp_cycle + 2) break;
            if (n >= CYC_LIMIT) begin
                o.timed_out = 1'b1;
                break;
            end
        end
        idle_bus();
    endtask

    // Expected outcome of a transaction, derived from the protocol's phase lengths.
    task automatic check_txn(input string nm, input stim_t s, input obs_t o);
        bit          exhaust;
        int          attempts, per, exp_cyc, exp_oe;
        bit          exp_err;
        logic [4:0]  exp_tt;
        exhaust  = (s.n_artry > RETRY_MAX);
        attempts = exhaust ? RETRY_MAX + 1 : s.n_artry + 1;
        per      = s.bg_w + s.aack_w + 3;            // BREQ + ADDR + AWAIT cycles
        exp_err  = exhaust || s.tea || s.never;
        if (exhaust)      exp_cyc = attempts * per + 1;
        else if (s.never) exp_cyc = attempts * per + TA_TIMEOUT + 1;
        else              exp_cyc = attempts * per + (s.dbg_w + 1) + (s.ta_w + 1) + 1;
        if (exhaust || !s.wr) exp_oe = 0;
        else if (s.never)     exp_oe = TA_TIMEOUT - (s.dbg_w + 1);
        else                  exp_oe = s.ta_w + 1;
        exp_tt = s.wr ? 5'b00010 : 5'b01010;

        check({nm, ".timeout"},   32'(o.timed_out), 32'd0);
        check({nm, ".rsp_count"}, o.rsp_count,      32'd1);
        check({nm, ".rsp_cycle"}, o.rsp_cycle,      exp_cyc);
        check({nm, ".rsp_err"},   32'(o.err),       32'(exp_err));
        check({nm, ".ts_count"},  o.ts_count,       attempts);
        check({nm, ".br_low"},    o.br_low,         attempts * (s.bg_w + 1));
        check({nm, ".A"},         o.a_ts,           s.addr);
        check({nm, ".TT"},        32'(o.tt_ts),     32'(exp_tt));
        check({nm, ".TSIZ"},      32'(o.tsiz_ts),   32'(s.size));
        check({nm, ".TBST"},      32'(o.tbst_ts),   32'd1);
        check({nm, ".hold"},      o.hold_bad,       32'd0);
        check({nm, ".ready"},     o.ready_bad,      32'd0);
        check({nm, ".oe_cycles"}, o.oe_cycles,      exp_oe);
        check({nm, ".oe_data"},   o.oe_bad,         32'd0);
        if (!s.wr && !exp_err) check({nm, ".rdata"}, o.rdata, s.rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        obs_t  o;
        int    rsp_seen;

        // ---- reset ----
        RST = 1'b1;
        idle_bus();
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("reset.release_ready", 32'(req_ready), 32'd0);
        @(negedge CLK);
        check("reset.next_ready", 32'(req_ready), 32'd1);

        // ---- zero-wait read ----
        s = base_stim();
        s.addr = 32'h0000_1000; s.size = 3'b100; s.rdata = 32'hAB00_0000;
        run_txn(s, o);
        check_txn("read0", s, o);

        // ---- write with BG0 delayed 3 cycles and TA held off ----
        s = base_stim();
        s.wr = 1'b1; s.addr = 32'h8000_0040; s.size = 3'b100; s.wdata = 32'h1234_5678;
        s.bg_w = 3; s.ta_w = 2;
        run_txn(s, o);
        check_txn("write_bg3", s, o);
        check("write_bg3.br0_low4", o.br_low, 32'd4);

        // ---- two retries then clean ----
        s = base_stim();
        s.addr = 32'h0000_2004; s.size = 3'b010; s.rdata = 32'h5A5A_1234; s.n_artry = 2;
        run_txn(s, o);
        check_txn("retry2", s, o);

        // ---- retry on every attempt: exhaust ----
        s = base_stim();
        s.wr = 1'b1; s.addr = 32'hFFFF_FFFC; s.wdata = 32'hDEAD_BEEF; s.n_artry = 99;
        run_txn(s, o);
        check_txn("retry_all", s, o);
        check("retry_all.ts9", o.ts_count, 32'd9);

        // ---- TA and TEA together ----
        s = base_stim();
        s.addr = 32'h0000_3000; s.rdata = 32'h1111_2222; s.tea = 1'b1; s.ta_w = 1;
        run_txn(s, o);
        check_txn("ta_tea", s, o);

        // ---- TA never: timeout ----
        s = base_stim();
        s.wr = 1'b1; s.addr = 32'h0000_4000; s.wdata = 32'h0F0F_0F0F; s.never = 1'b1;
        run_txn(s, o);
        check_txn("ta_never", s, o);

        // ---- randomized transactions ----
        for (int i = 0; i < 16; i++) begin
            s = base_stim();
            s.wr = ($urandom_range(0, 1) == 1);
            s.addr = $urandom; s.size = 3'($urandom_range(1, 7));
            s.wdata = $urandom; s.rdata = $urandom;
            s.bg_w = $urandom_range(0, 3); s.aack_w = $urandom_range(0, 3);
            s.dbg_w = $urandom_range(0, 3); s.ta_w = $urandom_range(0, 3);
            s.n_artry = $urandom_range(0, 2);
            s.tea = ($urandom_range(0, 7) == 0);
            s.junk = 1'b1;
            run_txn(s, o);
            check_txn($sformatf("rand%0d", i), s, o);
        end

        // ---- reset asserted during DATA ----
        idle_bus();
        @(negedge CLK);
        check("rst_data.ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_5000;
        req_size = 3'b100; req_wdata = 32'hCAFE_F00D;
        BG0 = 1'b0; AACK = 1'b0; ARTRY = 1'b1; DBG0 = 1'b0; TA = 1'b1; TEA = 1'b1;
        rsp_seen = 0;
        repeat (5) begin
            @(negedge CLK);
            req_valid = 1'b0;
            if (rsp_valid === 1'b1) rsp_seen++;
        end
        check("rst_data.in_data", 32'(DL_OE), 32'd1);
        #2 RST = 1'b1;
        #1;
        check_reset_vals("rst_data");
        repeat (2) begin
            @(negedge CLK);
            if (rsp_valid === 1'b1) rsp_seen++;
        end
        idle_bus();
        RST = 1'b0;
        check("rst_data.release_ready", 32'(req_ready), 32'd0);
        @(negedge CLK);
        if (rsp_valid === 1'b1) rsp_seen++;
        check("rst_data.next_ready", 32'(req_ready), 32'd1);
        check("rst_data.no_rsp", rsp_seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
